// File: rtl/vu_vmu_dcache_arb.sv
// Purpose: store-first arbiter putting the vector load (lrq) and store (srq) request queues onto the single D$ port.
// Latency: 0 cycles; the request path from lrq/srq to dcachereq is purely combinational.
// Backpressure: dcachereq_rdy=0 holds the current selection and keeps both deq_rdy low; loads also stall at MAX_LD_OUT.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   lrq_deq_bits/_val/_rdy          load request {addr[27:0], tag[7:0]}
//   srq_deq_bits/_val/_rdy          store request {addr[27:0], wmask[15:0], data[127:0]}
//   dcachereq_addr/_tag/_data/_wmask/_op/_val/_rdy   D$ request port
//   dcacheresp_tag/_val             D$ response; tag[11] set marks a store response (ignored)
//   fence_req, fence_done           drain fence: level request, one-cycle completion pulse
//   busy                            loads in flight or either queue has a request
// Optional: define VMU_DCACHE_ARB_PERF_EN to add perf_ld_grants, perf_st_grants, perf_ld_stall.
module vu_vmu_dcache_arb #(
  parameter int STORE_RUN_MAX = 8,
  parameter int MAX_LD_OUT    = 256,
  parameter int OUT_W         = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [35:0]   lrq_deq_bits,
  input  logic          lrq_deq_val,
  output logic          lrq_deq_rdy,
  input  logic [171:0]  srq_deq_bits,
  input  logic          srq_deq_val,
  output logic          srq_deq_rdy,
  output logic [27:0]   dcachereq_addr,
  output logic [11:0]   dcachereq_tag,
  output logic [127:0]  dcachereq_data,
  output logic [15:0]   dcachereq_wmask,
  output logic [3:0]    dcachereq_op,
  output logic          dcachereq_val,
  input  logic          dcachereq_rdy,
  input  logic [11:0]   dcacheresp_tag,
  input  logic          dcacheresp_val,
  input  logic          fence_req,
  output logic          fence_done,
  output logic          busy
`ifdef VMU_DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]   perf_ld_grants,
  output logic [31:0]   perf_st_grants,
  output logic [31:0]   perf_ld_stall
`endif
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FENCE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_LD_OUT);
  localparam logic [7:0]       RUN_MAX = 8'(STORE_RUN_MAX);

  typedef struct packed {
    logic [27:0] addr;
    logic [7:0]  tag;
  } ld_req_t;

  typedef struct packed {
    logic [27:0]  addr;
    logic [15:0]  wmask;
    logic [127:0] data;
  } st_req_t;

  ld_req_t          ld_req;
  st_req_t          st_req;
  logic [1:0]       state, state_nxt;
  logic [OUT_W-1:0] outstanding, out_nxt;
  logic [7:0]       store_run;
  logic             grant_en, ld_ok, st_ok, sel_ld, sel_st;
  logic             ld_fire, st_fire, ld_resp;
  logic             resp_tag_unused;

  assign ld_req = lrq_deq_bits;
  assign st_req = srq_deq_bits;

  // Only tag[11] matters here; load tags are tracked by the reorder queue.
  assign resp_tag_unused = ^dcacheresp_tag[10:0];

  // Grants stop in the very cycle fence_req is seen, not one cycle later,
  // and are held off entirely while reset is asserted.
  assign grant_en = ~reset & (state == ST_RUN) & ~fence_req;
  assign ld_ok    = lrq_deq_val & (outstanding < OUT_MAX) & grant_en;
  assign st_ok    = srq_deq_val & grant_en;

  // Stores win unless they have used up their run while a load waits.
  assign sel_ld   = ld_ok & (~st_ok | (store_run == RUN_MAX));
  assign sel_st   = st_ok & ~sel_ld;

  assign dcachereq_val   = sel_ld | sel_st;
  assign lrq_deq_rdy     = sel_ld & dcachereq_rdy;
  assign srq_deq_rdy     = sel_st & dcachereq_rdy;
  assign ld_fire         = lrq_deq_rdy;
  assign st_fire         = srq_deq_rdy;

  assign dcachereq_addr  = sel_st ? st_req.addr : ld_req.addr;
  assign dcachereq_tag   = sel_st ? 12'h800 : {4'd0, ld_req.tag};
  assign dcachereq_op    = sel_st ? 4'b0001 : 4'b0000;
  assign dcachereq_data  = st_req.data;
  assign dcachereq_wmask = st_req.wmask;

  assign ld_resp    = dcacheresp_val & ~dcacheresp_tag[11];
  assign fence_done = (state == ST_DONE);
  assign busy       = (outstanding != '0) | lrq_deq_val | srq_deq_val;

  // A response arriving in the same cycle as a load fire cancels out; a stray
  // response with nothing outstanding (e.g. left over from before a reset) is dropped.
  always_comb begin
    out_nxt = outstanding;
    if (ld_fire & ~ld_resp) begin
      out_nxt = outstanding + OUT_W'(1);
    end else if (ld_resp & ~ld_fire & (outstanding != '0)) begin
      out_nxt = outstanding - OUT_W'(1);
    end
  end

  // The fence completes on the post-update count, so the last response moves straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (fence_req) state_nxt = ST_FENCE;
      ST_FENCE: if (out_nxt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      outstanding <= '0;
      store_run   <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      // The run only counts stores that actually overtook a waiting load.
      if (~lrq_deq_val | ld_fire) begin
        store_run <= '0;
      end else if (st_fire & (store_run != RUN_MAX)) begin
        store_run <= store_run + 8'd1;
      end
    end
  end

`ifdef VMU_DCACHE_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_ld_grants <= '0;
      perf_st_grants <= '0;
      perf_ld_stall  <= '0;
    end else begin
      if (ld_fire)                 perf_ld_grants <= perf_ld_grants + 32'd1;
      if (st_fire)                 perf_st_grants <= perf_st_grants + 32'd1;
      if (lrq_deq_val & ~ld_fire)  perf_ld_stall  <= perf_ld_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vu_vmu_dcache_arb.sv
// Bench for vu_vmu_dcache_arb with default parameters (STORE_RUN_MAX=8, MAX_LD_OUT=256).
module tb_vu_vmu_dcache_arb;
  localparam int RUNMAX = 8;
  localparam int MAXOUT = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [35:0]   lrq_deq_bits;
  logic          lrq_deq_val;
  logic          lrq_deq_rdy;
  logic [171:0]  srq_deq_bits;
  logic          srq_deq_val;
  logic          srq_deq_rdy;
  logic [27:0]   dcachereq_addr;
  logic [11:0]   dcachereq_tag;
  logic [127:0]  dcachereq_data;
  logic [15:0]   dcachereq_wmask;
  logic [3:0]    dcachereq_op;
  logic          dcachereq_val;
  logic          dcachereq_rdy;
  logic [11:0]   dcacheresp_tag;
  logic          dcacheresp_val;
  logic          fence_req;
  logic          fence_done;
  logic          busy;
`ifdef VMU_DCACHE_ARB_PERF_EN
  logic [31:0]   perf_ld_grants, perf_st_grants, perf_ld_stall;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  vu_vmu_dcache_arb dut (
    .clk(clk), .reset(reset),
    .lrq_deq_bits(lrq_deq_bits), .lrq_deq_val(lrq_deq_val), .lrq_deq_rdy(lrq_deq_rdy),
    .srq_deq_bits(srq_deq_bits), .srq_deq_val(srq_deq_val), .srq_deq_rdy(srq_deq_rdy),
    .dcachereq_addr(dcachereq_addr), .dcachereq_tag(dcachereq_tag),
    .dcachereq_data(dcachereq_data), .dcachereq_wmask(dcachereq_wmask),
    .dcachereq_op(dcachereq_op), .dcachereq_val(dcachereq_val), .dcachereq_rdy(dcachereq_rdy),
    .dcacheresp_tag(dcacheresp_tag), .dcacheresp_val(dcacheresp_val),
    .fence_req(fence_req), .fence_done(fence_done), .busy(busy)
`ifdef VMU_DCACHE_ARB_PERF_EN
    , .perf_ld_grants(perf_ld_grants), .perf_st_grants(perf_st_grants),
    .perf_ld_stall(perf_ld_stall)
`endif
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle_inputs();
    lrq_deq_val = 1'b0; srq_deq_val = 1'b0; dcachereq_rdy = 1'b0;
    dcacheresp_val = 1'b0; dcacheresp_tag = '0; fence_req = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Fence with n loads outstanding: no grants until n responses are in,
  // fence_done exactly one cycle after the last response (2 cycles if n==0), then RUN again.
  task automatic drain_check(input string tn, input int n);
    fence_req = 1'b1; lrq_deq_val = 1'b1; srq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    @(negedge clk);
    chk({tn, "_rise_val"}, dcachereq_val, 0);
    chk({tn, "_rise_done"}, fence_done, 0);
    next_cycle();
    for (int i = 0; i < ((n > 0) ? n : 1); i++) begin
      dcacheresp_val = (i < n);
      dcacheresp_tag = 12'(i);
      @(negedge clk);
      chk({tn, "_wait_val"}, dcachereq_val, 0);
      chk({tn, "_wait_done"}, fence_done, 0);
      next_cycle();
    end
    dcacheresp_val = 1'b0;
    @(negedge clk);
    chk({tn, "_done_pulse"}, fence_done, 1);
    chk({tn, "_done_val"}, dcachereq_val, 0);
    next_cycle();
    fence_req = 1'b0;
    @(negedge clk);
    chk({tn, "_after_done"}, fence_done, 0);
    chk({tn, "_run_grant"}, dcachereq_val, 1);
    next_cycle();
  endtask

  typedef struct {
    logic l, s, r;
    logic e_val, e_lr, e_sr;
    logic [3:0] e_op;
  } vec_t;

  vec_t tbl[18];

  // Reference model state: loads in flight, consecutive stores passing a waiting load, fence phase.
  int        m_out, m_run, m_ph;   // m_ph: 0 run, 1 fencing, 2 done
  logic [7:0] tq[$];

  initial begin
    int fires;
    logic [171:0] sbits;
    logic [127:0] tmp;

    // 12 cycles of both queues valid: 8 stores, 1 load, 3 stores; then hold/mix cases.
    for (int i = 0; i < 12; i++)
      tbl[i] = '{1, 1, 1, 1, (i == 8), (i != 8), (i == 8) ? 4'd0 : 4'd1};
    tbl[12] = '{1, 1, 0, 1, 0, 0, 4'd1};
    tbl[13] = '{1, 1, 0, 1, 0, 0, 4'd1};
    tbl[14] = '{0, 1, 0, 1, 0, 0, 4'd1};
    tbl[15] = '{1, 0, 1, 1, 1, 0, 4'd0};
    tbl[16] = '{0, 0, 1, 0, 0, 0, 4'd0};
    tbl[17] = '{1, 1, 1, 1, 0, 1, 4'd1};

    lrq_deq_bits = 36'h123456_7AB;
    srq_deq_bits = '0;
    idle_inputs();

    // Reset state with both queues pushing: nothing may be granted.
    lrq_deq_val = 1'b1; srq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    #2;
    chk("rst_val", dcachereq_val, 0);
    chk("rst_lrdy", lrq_deq_rdy, 0);
    chk("rst_srdy", srq_deq_rdy, 0);
    chk("rst_fence_done", fence_done, 0);
    do_reset();

    // Table vectors.
    for (int i = 0; i < 18; i++) begin
      lrq_deq_val = tbl[i].l; srq_deq_val = tbl[i].s; dcachereq_rdy = tbl[i].r;
      @(negedge clk);
      chk($sformatf("tbl%0d_val", i), dcachereq_val, tbl[i].e_val);
      chk($sformatf("tbl%0d_lrdy", i), lrq_deq_rdy, tbl[i].e_lr);
      chk($sformatf("tbl%0d_srdy", i), srq_deq_rdy, tbl[i].e_sr);
      chk($sformatf("tbl%0d_op", i), dcachereq_op, tbl[i].e_op);
      next_cycle();
    end

    // Outstanding limit: 256 loads fire, then stall; a response frees one slot the next cycle.
    do_reset();
    lrq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    fires = 0;
    for (int i = 0; i < MAXOUT; i++) begin
      @(negedge clk);
      if (lrq_deq_rdy) fires++;
      next_cycle();
    end
    chk("cap_fires", fires, MAXOUT);
    @(negedge clk);
    chk("cap_full_rdy", lrq_deq_rdy, 0);
    chk("cap_full_val", dcachereq_val, 0);
    next_cycle();
    dcacheresp_val = 1'b1; dcacheresp_tag = 12'h005;
    @(negedge clk);
    chk("cap_resp_same_cycle", lrq_deq_rdy, 0);
    next_cycle();
    dcacheresp_val = 1'b0;
    @(negedge clk);
    chk("cap_freed", lrq_deq_rdy, 1);
    next_cycle();
    @(negedge clk);
    chk("cap_full_again", lrq_deq_rdy, 0);
    next_cycle();

    // Fire + response together at 5 outstanding, then a store response: count must stay 5.
    do_reset();
    lrq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    repeat (5) next_cycle();
    dcacheresp_val = 1'b1; dcacheresp_tag = 12'h003;
    @(negedge clk);
    chk("both_fire", lrq_deq_rdy, 1);
    next_cycle();
    lrq_deq_val = 1'b0; dcacheresp_tag = 12'h800;
    next_cycle();
    dcacheresp_val = 1'b0;
    drain_check("fence5", 5);

    do_reset();
    lrq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    repeat (3) next_cycle();
    lrq_deq_val = 1'b0;
    drain_check("fence3", 3);

    do_reset();
    drain_check("fence0", 0);

    // Backpressure: selection and payload hold while rdy=0.
    do_reset();
    sbits = {28'hABCDE12, 16'h5A5A, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
    srq_deq_bits = sbits;
    lrq_deq_val = 1'b1; srq_deq_val = 1'b1; dcachereq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lrq_deq_bits = 36'(i * 36'h1_0000_0101);
      @(negedge clk);
      chk("hold_val", dcachereq_val, 1);
      chk("hold_srdy", srq_deq_rdy, 0);
      chk("hold_lrdy", lrq_deq_rdy, 0);
      chk("hold_addr", dcachereq_addr, 28'hABCDE12);
      chk("hold_op", dcachereq_op, 4'd1);
      chk("hold_tag", dcachereq_tag, 12'h800);
      chk("hold_wmask", dcachereq_wmask, 16'h5A5A);
      tmp = sbits[127:0];
      chk("hold_data", dcachereq_data, tmp);
      next_cycle();
    end

    // Reset in the middle of a fence with two loads in flight.
    srq_deq_val = 1'b0; dcachereq_rdy = 1'b1;
    repeat (2) next_cycle();
    fence_req = 1'b1; srq_deq_val = 1'b1;
    repeat (2) next_cycle();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_val", dcachereq_val, 0);
    chk("mid_rst_lrdy", lrq_deq_rdy, 0);
    chk("mid_rst_srdy", srq_deq_rdy, 0);
    chk("mid_rst_done", fence_done, 0);
    next_cycle();
    chk("mid_rst_val2", dcachereq_val, 0);
    idle_inputs();
    reset = 1'b0;
    dcacheresp_val = 1'b1;
    for (int i = 0; i < 2; i++) begin
      dcacheresp_tag = 12'(i);
      next_cycle();
    end
    dcacheresp_val = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    next_cycle();
    drain_check("post_rst_fence", 0);

`ifdef VMU_DCACHE_ARB_PERF_EN
    do_reset();
    @(negedge clk);
    chk("perf_rst_ld", perf_ld_grants, 0);
    chk("perf_rst_st", perf_st_grants, 0);
    chk("perf_rst_stall", perf_ld_stall, 0);
    next_cycle();
    lrq_deq_val = 1'b1; dcachereq_rdy = 1'b1;
    repeat (4) next_cycle();
    dcachereq_rdy = 1'b0;
    repeat (3) next_cycle();
    lrq_deq_val = 1'b0;
    @(negedge clk);
    chk("perf_ld_grants", perf_ld_grants, 4);
    chk("perf_ld_stall", perf_ld_stall, 3);
    chk("perf_st_grants", perf_st_grants, 0);
    next_cycle();
`endif

    // Randomized run against the reference model.
    do_reset();
    m_out = 0; m_run = 0; m_ph = 0;
    tq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit en, lok, sok, eld, est, lf, sf, rl, drop;
      int k;
      lrq_deq_val   = ($urandom_range(0, 9) != 0);
      srq_deq_val   = ($urandom_range(0, 9) < 8);
      dcachereq_rdy = ($urandom_range(0, 3) != 0);
      lrq_deq_bits  = 36'({$urandom(), $urandom()});
      srq_deq_bits  = 172'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      dcacheresp_val = 1'b0;
      dcacheresp_tag = '0;
      if (tq.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, tq.size() - 1);
        dcacheresp_val = 1'b1;
        dcacheresp_tag = {4'd0, tq[k]};
        tq.delete(k);
      end else if ($urandom_range(0, 7) == 0) begin
        dcacheresp_val = 1'b1;
        dcacheresp_tag = 12'h800 | 12'($urandom_range(0, 2047));
      end
      if (!fence_req && $urandom_range(0, 99) == 0) fence_req = 1'b1;

      @(negedge clk);
      en  = (m_ph == 0) && !fence_req;
      lok = lrq_deq_val && (m_out < MAXOUT) && en;
      sok = srq_deq_val && en;
      eld = lok && (!sok || m_run >= RUNMAX);
      est = sok && !eld;
      chk("rnd_val", dcachereq_val, eld || est);
      chk("rnd_lrdy", lrq_deq_rdy, eld && dcachereq_rdy);
      chk("rnd_srdy", srq_deq_rdy, est && dcachereq_rdy);
      chk("rnd_fence_done", fence_done, m_ph == 2);
      chk("rnd_busy", busy, (m_out != 0) || lrq_deq_val || srq_deq_val);
      chk("rnd_data", dcachereq_data, srq_deq_bits[127:0]);
      chk("rnd_wmask", dcachereq_wmask, srq_deq_bits[143:128]);
      if (eld || est) begin
        chk("rnd_op", dcachereq_op, est ? 4'd1 : 4'd0);
        chk("rnd_addr", dcachereq_addr, est ? srq_deq_bits[171:144] : lrq_deq_bits[35:8]);
        chk("rnd_tag", dcachereq_tag, est ? 12'h800 : {4'd0, lrq_deq_bits[7:0]});
      end

      lf = eld && dcachereq_rdy;
      sf = est && dcachereq_rdy;
      rl = dcacheresp_val && !dcacheresp_tag[11];
      drop = (m_ph == 2);
      if (lf) tq.push_back(lrq_deq_bits[7:0]);
      m_out = m_out + int'(lf) - int'(rl);
      if (m_out < 0) m_out = 0;
      if (!lrq_deq_val || lf) m_run = 0;
      else if (sf && m_run < RUNMAX) m_run++;
      if (m_ph == 2) m_ph = 0;
      else if (m_ph == 1) begin
        if (m_out == 0) m_ph = 2;
      end else if (fence_req) m_ph = 1;
      next_cycle();
      if (drop) fence_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
